// File: rtl/counter_display_pkg.sv
// rtl/counter_display_pkg.sv - shared digit count, conversion FSM states and 7-segment encodings
package counter_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction step: add 3 to every BCD nibble that is 5 or more
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_display_if.sv
// rtl/counter_display_if.sv - counter input and display output bundle with master/slave views
interface counter_display_if
  import counter_display_pkg::*;
#(
  parameter int N = 4
);
  logic [N-1:0]            counterN;
  logic                    threshold;
  logic                    hold;
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    dp;
  logic                    busy;

  modport master (
    output counterN, threshold, hold,
    input  segments, anodes, dp, busy
  );

  modport slave (
    input  counterN, threshold, hold,
    output segments, anodes, dp, busy
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter, one bit per cycle
module bin_to_bcd_seq
  import counter_display_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] value_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  bcd_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  conv_state_e   state_q, state_d;
  logic [N-1:0]  bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   adj;

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: latch on start, N adjust-and-shift steps, then one DONE cycle
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = dabble_adjust(bcd_q);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[14:0], bin_q[N-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/counter_display.sv
// rtl/counter_display.sv - 4-digit multiplexed 7-seg display of a binary counter with threshold blink (option: LEADING_ZERO_BLANK_EN)
module counter_display
  import counter_display_pkg::*;
#(
  parameter int N           = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic              clock,
  input logic              reset,
  counter_display_if.slave bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

  logic [N-1:0]  last_q, last_d;
  logic [15:0]   display_q, display_d;
  logic [15:0]   conv_bcd;
  logic          conv_start, conv_busy, conv_done;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d, blink_cnt_eff;
  logic          phase_q, phase_d, phase_eff;
  logic          thr_prev_q, thr_rise;
  logic [3:0]    nibble;
  logic          digit_on;
  logic          dark;

  // A new conversion starts only from idle, when not frozen and the input moved
  assign conv_start = !bus.hold && !conv_busy && (bus.counterN != last_q);

  bin_to_bcd_seq #(.N(N)) u_bin_to_bcd (
    .clk_i   (clock),
    .rst_ni  (reset),
    .start_i (conv_start),
    .value_i (bus.counterN),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign bus.busy = conv_busy;

  // Track the value being converted and publish the finished result atomically
  always_comb begin
    last_d    = last_q;
    display_d = display_q;
    if (conv_start) last_d = bus.counterN;
    if (conv_done)  display_d = conv_bcd;
  end

  // Scan timing: one digit slot per REFRESH_DIV cycles
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    if (refresh_q == REFRESH_MAX) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end
  end

  // Blink timing; a threshold rising edge restarts the ON phase in that same cycle
  always_comb begin
    thr_rise      = bus.threshold && !thr_prev_q;
    blink_cnt_eff = thr_rise ? '0 : blink_cnt_q;
    phase_eff     = thr_rise | phase_q;
    if (blink_cnt_eff == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = !phase_eff;
    end else begin
      blink_cnt_d = blink_cnt_eff + 1'b1;
      phase_d     = phase_eff;
    end
  end

  // All registers of the top level
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q      <= '0;
      display_q   <= '0;
      refresh_q   <= '0;
      digit_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      thr_prev_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      display_q   <= display_d;
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      thr_prev_q  <= bus.threshold;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  // Most significant nonzero digit; digit 0 stays lit even for a zero value
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display_q[i*4 +: 4] != 4'd0) msd = 2'(i);
    end
  end

  assign digit_on = (digit_q <= msd);
`else
  assign digit_on = 1'b1;
`endif

  // Output decode: selected nibble, anode select with blink blanking, decimal point
  always_comb begin
    nibble       = display_q[{digit_q, 2'b00} +: 4];
    dark         = bus.threshold && !phase_eff;
    bus.segments = seg_decode(nibble);
    bus.anodes   = '1;
    if (digit_on && !dark) bus.anodes[digit_q] = 1'b0;
    bus.dp       = !(bus.threshold && phase_eff && (digit_q == 2'd0));
  end

endmodule

// File: tb/tb_counter_display.sv
// tb/tb_counter_display.sv - directed self-checking bench for counter_display
module tb_counter_display;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  counter_display_if #(.N(4))  if4 ();
  counter_display_if #(.N(13)) if13 ();

  counter_display #(.N(4), .REFRESH_DIV(4), .BLINK_DIV(8)) dut4 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if4)
  );

  counter_display #(.N(13), .REFRESH_DIV(4), .BLINK_DIV(8)) dut13 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Samples 16 cycles of dut4 and records the segments seen for each lit digit
  task automatic scan4(output logic [27:0] segs, output logic [3:0] seen, output int bad);
    int lows;
    segs = '1;
    seen = '0;
    bad  = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      lows = 0;
      for (int k = 0; k < 4; k++) begin
        if (!if4.anodes[k]) begin
          lows++;
          seen[k] = 1'b1;
          segs[k*7 +: 7] = if4.segments;
        end
      end
      if (lows > 1) bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if4.counterN = '0;   if4.threshold = 1'b0;  if4.hold = 1'b0;
    if13.counterN = '0;  if13.threshold = 1'b0; if13.hold = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (if4.anodes !== 4'b1110) $display("FAIL reset_anodes: got %b expected 1110", if4.anodes); else pass_cnt++;
    total_cnt++;
    if (if4.segments !== 7'b1000000) $display("FAIL reset_segments: got %b expected 1000000", if4.segments); else pass_cnt++;
    total_cnt++;
    if (if4.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", if4.busy); else pass_cnt++;
    total_cnt++;
    if (if4.dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", if4.dp); else pass_cnt++;
    total_cnt++;
    if (if13.anodes !== 4'b1110) $display("FAIL reset_anodes13: got %b expected 1110", if13.anodes); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_convert();
    int busy_cnt;
    logic [15:0] d5, d6;
    logic [27:0] segs;
    logic [3:0] seen;
    int bad;
    busy_cnt = 0;
    d5 = 'x;
    d6 = 'x;
    if4.counterN = 4'd9;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (if4.busy === 1'b1) busy_cnt++;
      if (k == 5) d5 = dut4.display_q;
      if (k == 6) d6 = dut4.display_q;
    end
    total_cnt++;
    if (busy_cnt != 5) $display("FAIL conv_busy_cycles: got %0d expected 5", busy_cnt); else pass_cnt++;
    total_cnt++;
    if (d5 !== 16'h0000) $display("FAIL conv_no_partial: got %h expected 0000", d5); else pass_cnt++;
    total_cnt++;
    if (d6 !== 16'h0009) $display("FAIL conv_latency: got %h expected 0009", d6); else pass_cnt++;
    scan4(segs, seen, bad);
    total_cnt++;
    if (segs[6:0] !== 7'b0010000) $display("FAIL conv_units_seg: got %b expected 0010000", segs[6:0]); else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL conv_one_hot: got %0d multi-low cycles expected 0", bad); else pass_cnt++;
  endtask

  task automatic test_n13();
    logic [15:0] d14, d15;
    logic [3:0] prev, exp_an;
    logic [27:0] segs;
    logic [27:0] exp_segs;
    int found, an_err;
    d14 = 'x;
    d15 = 'x;
    if13.counterN = 13'd8191;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 14) d14 = dut13.display_q;
      if (k == 15) d15 = dut13.display_q;
    end
    total_cnt++;
    if (d14 !== 16'h0000) $display("FAIL n13_early: got %h expected 0000", d14); else pass_cnt++;
    total_cnt++;
    if (d15 !== 16'h8191) $display("FAIL n13_result: got %h expected 8191", d15); else pass_cnt++;
    found = 0;
    prev = if13.anodes;
    for (int t = 0; t < 24 && found == 0; t++) begin
      @(negedge clk);
      if (if13.anodes == 4'b1110 && prev != 4'b1110) found = 1;
      prev = if13.anodes;
    end
    total_cnt++;
    if (found != 1) $display("FAIL n13_slot_align: got %0d expected 1", found); else pass_cnt++;
    an_err = 0;
    segs = '1;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      exp_an = 4'hF;
      exp_an[j/4] = 1'b0;
      if (if13.anodes !== exp_an) an_err++;
      if (j % 4 == 0) segs[(j/4)*7 +: 7] = if13.segments;
    end
    total_cnt++;
    if (an_err != 0) $display("FAIL n13_anode_order: got %0d bad cycles expected 0", an_err); else pass_cnt++;
    exp_segs = {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001};
    total_cnt++;
    if (segs !== exp_segs) $display("FAIL n13_digits: got %h expected %h", segs, exp_segs); else pass_cnt++;
  endtask

  task automatic test_leading_zero();
    logic [27:0] segs;
    logic [3:0] seen;
    int bad;
    if4.counterN = 4'd5;
    repeat (8) @(negedge clk);
    scan4(segs, seen, bad);
    total_cnt++;
    if (segs[6:0] !== 7'b0010010) $display("FAIL lz_units_seg: got %b expected 0010010", segs[6:0]); else pass_cnt++;
`ifdef LEADING_ZERO_BLANK_EN
    total_cnt++;
    if (seen !== 4'b0001) $display("FAIL lz_blanked: got %b expected 0001", seen); else pass_cnt++;
`else
    total_cnt++;
    if (seen !== 4'b1111) $display("FAIL lz_all_scanned: got %b expected 1111", seen); else pass_cnt++;
    total_cnt++;
    if (segs[27:7] !== {3{7'b1000000}}) $display("FAIL lz_zero_digits: got %h expected %h", segs[27:7], {3{7'b1000000}}); else pass_cnt++;
`endif
  endtask

  task automatic test_hold();
    int busy_cnt;
    logic [15:0] d5, d6;
    logic [27:0] segs;
    logic [3:0] seen;
    int bad;
    if4.counterN = 4'd3;
    repeat (8) @(negedge clk);
    if4.hold = 1'b1;
    if4.counterN = 4'd7;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if4.busy !== 1'b0) busy_cnt++;
    end
    total_cnt++;
    if (busy_cnt != 0) $display("FAIL hold_busy: got %0d busy cycles expected 0", busy_cnt); else pass_cnt++;
    scan4(segs, seen, bad);
    total_cnt++;
    if (segs[6:0] !== 7'b0110000) $display("FAIL hold_digit: got %b expected 0110000", segs[6:0]); else pass_cnt++;
    if4.hold = 1'b0;
    d5 = 'x;
    d6 = 'x;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) d5 = dut4.display_q;
      if (k == 6) d6 = dut4.display_q;
    end
    total_cnt++;
    if (d5 !== 16'h0003) $display("FAIL hold_release_early: got %h expected 0003", d5); else pass_cnt++;
    total_cnt++;
    if (d6 !== 16'h0007) $display("FAIL hold_release: got %h expected 0007", d6); else pass_cnt++;
  endtask

  task automatic test_blink();
    int lit_err, dp_err, dark_cnt;
    logic lit, exp_lit, exp_dp;
    lit_err = 0;
    dp_err = 0;
    if13.threshold = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      lit = (if13.anodes != 4'hF);
      exp_lit = ((k / 8) % 2) == 0;
      if (lit !== exp_lit) lit_err++;
      exp_dp = !(lit && if13.anodes == 4'b1110);
      if (if13.dp !== exp_dp) dp_err++;
    end
    total_cnt++;
    if (lit_err != 0) $display("FAIL blink_phase: got %0d wrong cycles expected 0", lit_err); else pass_cnt++;
    total_cnt++;
    if (dp_err != 0) $display("FAIL blink_dp: got %0d wrong cycles expected 0", dp_err); else pass_cnt++;
    @(negedge clk);
    if13.threshold = 1'b0;
    dark_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (if13.anodes == 4'hF || if13.dp !== 1'b1) dark_cnt++;
    end
    total_cnt++;
    if (dark_cnt != 0) $display("FAIL blink_off_continuous: got %0d bad cycles expected 0", dark_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [15:0] d6;
    if4.counterN = 4'd12;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (if4.busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", if4.busy); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (if4.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", if4.busy); else pass_cnt++;
    total_cnt++;
    if (dut4.display_q !== 16'h0000) $display("FAIL abort_display: got %h expected 0000", dut4.display_q); else pass_cnt++;
    total_cnt++;
    if (if4.segments !== 7'b1000000 || if4.anodes !== 4'b1110)
      $display("FAIL abort_outputs: got %b/%b expected 1000000/1110", if4.segments, if4.anodes);
    else pass_cnt++;
    rst_n = 1'b1;
    d6 = 'x;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) d6 = dut4.display_q;
    end
    total_cnt++;
    if (d6 !== 16'h0012) $display("FAIL abort_restart: got %h expected 0012", d6); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_convert();
    test_n13();
    test_leading_zero();
    test_hold();
    test_blink();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/counter_display.md
COUNTER_DISPLAY -- requirements
Module: counter_display

Interface
REQ-001 Parameter N, default 4, width of counter value input; legal range 1..13.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles per digit scan slot; minimum 2.
REQ-003 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period; minimum 2.
REQ-004 clock  input  1  single system clock; all state rising-edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 counterN  input  N  unsigned value from the upstream counter.
REQ-007 threshold  input  1  upstream threshold flag; level-sensitive.
REQ-008 hold  input  1  1 = freeze displayed value, no new conversions start.
REQ-009 segments  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 anodes  output  4  digit enables, active-low; anodes[0] = units digit.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 busy  output  1  1 while a binary-to-BCD conversion is in progress.

Function
REQ-013 Conversion FSM SHALL have states IDLE, SHIFT, DONE.
REQ-014 IDLE: when hold=0 and counterN differs from last converted value, latch counterN and go to SHIFT.
REQ-015 SHIFT: sequential double-dabble (add 3 to any BCD nibble >=5, then shift left 1), exactly N cycles, then DONE.
REQ-016 DONE: load 16-bit BCD result into display register in one cycle, return to IDLE.
REQ-017 Latency from counterN change (sampled in IDLE) to display register update SHALL be N+2 cycles.
REQ-018 counterN changes during SHIFT/DONE SHALL be ignored until IDLE; last value always converted eventually.
REQ-019 busy SHALL be 1 exactly in SHIFT and DONE.
REQ-020 Refresh counter counts 0..REFRESH_DIV-1; on wrap digit index advances 0->1->2->3->0.
REQ-021 Exactly one anode low at a time, selected by digit index, except during blink-off phase.
REQ-022 segments SHALL show hex-to-7seg of selected BCD nibble; nibble values >9 never occur.
REQ-023 Blink counter counts 0..BLINK_DIV-1, toggling blink phase on wrap.
REQ-024 Rising edge of threshold SHALL reset blink counter and set phase ON in the same cycle.
REQ-025 threshold=1 and phase OFF: all anodes high (display dark); phase ON: normal display.
REQ-026 dp low only when threshold=1, phase ON, and digit index=0; else high.
REQ-027 threshold=0: blink ignored, display continuous.
REQ-028 Display register retains previous value during conversion; no partial results visible.

Reset
REQ-029 reset=0 on a rising edge: FSM IDLE, display register 0, last-converted value 0, refresh counter 0, digit index 0, blink counter 0, phase ON.
REQ-030 Outputs during/after reset: anodes=4'b1110, segments=7'b1000000 ("0"), dp=1, busy=0.
REQ-031 Reset mid-conversion SHALL abort it; display shows 0; a nonzero counterN restarts conversion on the first non-reset IDLE cycle.

Configuration
REQ-032 Macro LEADING_ZERO_BLANK_EN defined: digits above most significant nonzero digit SHALL have anode high; digit 0 always lit.
REQ-033 Macro undefined: all four digits scanned, leading zeros displayed as "0".

Structure
REQ-034 Package counter_display_pkg SHALL hold NUM_DIGITS=4, FSM state typedef, and 7-segment encoding constants for 0..9.
REQ-035 Sub-module bin_to_bcd_seq SHALL implement the double-dabble FSM (start/value in, busy/bcd out); top keeps scan, blink, decode.

Verification (N=4, REFRESH_DIV=4, BLINK_DIV=8)
REQ-036 Reset low 2 cycles -> anodes=1110, segments=1000000, busy=0, dp=1.
REQ-037 counterN 0->9 -> busy high 5 cycles, display register 0x0009 at cycle 6, units segments=0010000.
REQ-038 N=13, counterN=8191 -> display digits 8,1,9,1 after 15 cycles; each anode low 4 cycles in order 0,1,2,3.
REQ-039 threshold 0->1 -> display lit 8 cycles, dark 8 cycles, repeating; dp low only in digit 0 slots while lit.
REQ-040 hold=1, counterN 3->7 -> busy stays 0, digit 0 still "3"; hold=0 -> "7" after 6 cycles.
REQ-041 With LEADING_ZERO_BLANK_EN, counterN=5 -> anodes[3:1] never low; without it, digits 3..1 show "0".
